multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the datapath and drives every mux select and write strobe: PC, IR, memory, register file and ALU.
- Decodes opcode/funct from the instruction register once per instruction and sequences FETCH → DECODE → per-class execute states.
- Consumes the ALU zero flag for beq.

Parameters:
- HALT_ON_ILLEGAL, 0, 1 = unknown opcode/funct enters HALT and stays there until reset; 0 = it returns to FETCH as a no-op.

Ports:
- clock  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; forces FETCH
- instr  in  32  instruction register contents; only [31:26] and [5:0] are used
- zero  in  1  ALU result == 0 (combinational from ALU)
- PCWrite  out  1  PC register enable
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  instruction register enable
- memWrite  out  1  data memory write strobe
- memToReg  out  1  register writeback select: 0 = ALUOut, 1 = memory data register
- regDst  out  1  destination select: 1 = rd, 0 = rt
- jump  out  1  forces A3 = 31 (jal link)
- regWriteEnable  out  1  register file write enable
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUControl  out  5  ADD 00010, SUB 00110, AND 00000, OR 00001, SLT 00111, PASSA 01000
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target, 11 = RD1 (jr)
- branchEnable  out  1  high in BRANCH state (debug/observability)
- jumpReg  out  1  high in JR state
- state  out  4  current state code

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, JALX 12, JALW 13, JR 14, HALT 15.
- Reset: state = FETCH asynchronously. While reset is high, PCWrite, IRWrite, memWrite and regWriteEnable are forced 0. All other outputs follow FETCH decode.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state is chosen from opcode:
  - 100011 → MEMADR
  - 101011 → MEMADR
  - 000000 with funct 001000 → JR
  - other 000000 → RTEX
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP
  - 000011 → JALX
  - anything else → illegal handling
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: IorD=1 → MEMWB.
- MEMWB: memToReg=1, regDst=0, regWriteEnable=1 → FETCH.
- MEMWR: IorD=1, memWrite=1 → FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUControl from funct:
  - 100000 ADD
  - 100010 SUB
  - 100100 AND
  - 100101 OR
  - 101010 SLT
  - other funct → illegal handling
  - → RTWB
- RTWB: regDst=1, memToReg=0, regWriteEnable=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, branchEnable=1, PCSrc=01, PCWrite=zero → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD → ADDIWB.
- ADDIWB: regDst=0, memToReg=0, regWriteEnable=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.
- JALX: ALUSrcA=0, PASSA (ALUOut ← PC+4) → JALW.
- JALW: jump=1, memToReg=0, regWriteEnable=1, PCSrc=10, PCWrite=1 → FETCH.
- JR: jumpReg=1, PCSrc=11, PCWrite=1 → FETCH.
- HALT: all strobes 0; self-loop.
- Any output not listed for a state is 0, with ALUControl defaulting to ADD.
- Latency in cycles, FETCH inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, jal 4, jr 3.
- instr is sampled only in DECODE, RTEX and MEMADR. IR holds during these states because IRWrite=0 outside FETCH.
- Reset asserted mid-instruction aborts it immediately, with no further writes. The first posedge after deassertion executes FETCH.

Optional Feature:
- Macro BNE_SUPPORT_EN.
- Defined: opcode 000101 in DECODE → BRANCH, with PCWrite = ~zero for that instruction (a 1-bit bne flag is latched in DECODE).
- Undefined: 000101 is illegal and handled per HALT_ON_ILLEGAL.

Test Plan:
- Reset high for 2 cycles, then release → state=0. PCWrite/IRWrite/memWrite/regWriteEnable stay 0 during reset and are 1 (PCWrite, IRWrite) in the first cycle after release.
- lw (instr=8C220004) → states 0,1,2,3,4. IorD=1 in state 3. regWriteEnable=1, memToReg=1 only in state 4.
- sw (AC220004) → states 0,1,2,5. memWrite=1 for exactly one cycle. regWriteEnable never asserted.
- beq (10220003) with zero=1 → PCWrite=1, PCSrc=01 in state 8. Repeat with zero=0 → PCWrite=0. Both return to state 0.
- R-type or (00221825) → ALUControl=00001 in state 6, regDst=1 write in state 7. jr (03E00008) → state 14, PCSrc=11, jumpReg=1.
- jal (0C000010) → states 0,1,12,13. jump=1, regWriteEnable=1, PCSrc=10 in state 13. Illegal opcode 111111 with HALT_ON_ILLEGAL=1 → state 15 held until reset. Reset asserted in state 3 → state 0 at once, no register write.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control
// ----------------------------------------------------------------------------
// Moore control FSM for the multicycle MIPS datapath. Decodes opcode/funct
// from the instruction register and steps FETCH -> DECODE -> class-specific
// execute states, driving every mux select and write strobe in the datapath.
//
// Parameters:
//   HALT_ON_ILLEGAL : 1 = unknown opcode/funct parks the FSM in HALT until
//                     reset; 0 = it falls back to FETCH as a no-op.
//
// Optional feature macro:
//   BNE_SUPPORT_EN  : when defined, opcode 000101 (bne) shares the BRANCH
//                     state with beq and takes the branch on ~zero.
//
// Ports:
//   clock, reset        : clock (posedge) and async active-high reset
//   instr[31:0]         : IR contents; only [31:26] and [5:0] are decoded
//   zero                : ALU result == 0, used by the branch states
//   PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, jump,
//   regWriteEnable, ALUSrcA, ALUSrcB[1:0], ALUControl[4:0], PCSrc[1:0]
//                       : datapath controls
//   branchEnable, jumpReg, state[3:0] : observability outputs
// ============================================================================
module multicycle_control #(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        IRWrite,
    output logic        memWrite,
    output logic        memToReg,
    output logic        regDst,
    output logic        jump,
    output logic        regWriteEnable,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [4:0]  ALUControl,
    output logic [1:0]  PCSrc,
    output logic        branchEnable,
    output logic        jumpReg,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEX   = 4'd6,  RTWB   = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11,
        JALX   = 4'd12, JALW   = 4'd13, JR     = 4'd14, HALT   = 4'd15
    } stateT;

    typedef struct packed {
        logic       pcWrite;
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       jump;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [4:0] aluControl;
        logic [1:0] pcSrc;
        logic       branchEnable;
        logic       jumpReg;
    } ctrlT;

    localparam logic [4:0] ALU_ADD   = 5'b00010;
    localparam logic [4:0] ALU_SUB   = 5'b00110;
    localparam logic [4:0] ALU_AND   = 5'b00000;
    localparam logic [4:0] ALU_OR    = 5'b00001;
    localparam logic [4:0] ALU_SLT   = 5'b00111;
    localparam logic [4:0] ALU_PASSA = 5'b01000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
`ifdef BNE_SUPPORT_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    stateT      curState;
    stateT      nextState;
    stateT      illegalTarget;
    ctrlT       ctrlReg;
    ctrlT       ctrlNext;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] functAlu;
    logic       functLegal;
    logic       branchTaken;
    logic       unusedInstrBits;
`ifdef BNE_SUPPORT_EN
    logic       bneFlag;
`endif

    assign opcode          = instr[31:26];
    assign funct           = instr[5:0];
    assign unusedInstrBits = ^instr[25:6];
    assign illegalTarget   = HALT_ON_ILLEGAL ? HALT : FETCH;

    // Control word for a given state; RTEX is the only state whose word
    // depends on the instruction (ALU operation chosen from funct).
    function automatic ctrlT ctrlFor(input stateT s, input logic [4:0] rtAlu);
        ctrlT c;
        c            = '0;
        c.aluControl = ALU_ADD;
        case (s)
            FETCH:  begin c.irWrite = 1'b1; c.pcWrite = 1'b1; c.aluSrcB = 2'b01; end
            DECODE: begin c.aluSrcB = 2'b11; end
            MEMADR: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            MEMRD:  begin c.iorD = 1'b1; end
            MEMWB:  begin c.memToReg = 1'b1; c.regWrite = 1'b1; end
            MEMWR:  begin c.iorD = 1'b1; c.memWrite = 1'b1; end
            RTEX:   begin c.aluSrcA = 1'b1; c.aluControl = rtAlu; end
            RTWB:   begin c.regDst = 1'b1; c.regWrite = 1'b1; end
            BRANCH: begin
                c.aluSrcA      = 1'b1;
                c.aluControl   = ALU_SUB;
                c.branchEnable = 1'b1;
                c.pcSrc        = 2'b01;
            end
            ADDIEX: begin c.aluSrcA = 1'b1; c.aluSrcB = 2'b10; end
            ADDIWB: begin c.regWrite = 1'b1; end
            JUMP:   begin c.pcSrc = 2'b10; c.pcWrite = 1'b1; end
            JALX:   begin c.aluControl = ALU_PASSA; end
            JALW:   begin
                c.jump     = 1'b1;
                c.regWrite = 1'b1;
                c.pcSrc    = 2'b10;
                c.pcWrite  = 1'b1;
            end
            JR:     begin c.jumpReg = 1'b1; c.pcSrc = 2'b11; c.pcWrite = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // R-type funct decode: ALU operation plus a legality flag for RTEX exit.
    always_comb begin
        functAlu   = ALU_ADD;
        functLegal = 1'b1;
        case (funct)
            6'b100000: functAlu = ALU_ADD;
            6'b100010: functAlu = ALU_SUB;
            6'b100100: functAlu = ALU_AND;
            6'b100101: functAlu = ALU_OR;
            6'b101010: functAlu = ALU_SLT;
            default:   functLegal = 1'b0;
        endcase
    end

    // Next-state selection; instr is only consulted in DECODE, MEMADR, RTEX.
    always_comb begin
        nextState = FETCH;
        case (curState)
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = (funct == FN_JR) ? JR : RTEX;
                    OP_BEQ:       nextState = BRANCH;
`ifdef BNE_SUPPORT_EN
                    OP_BNE:       nextState = BRANCH;
`endif
                    OP_ADDI:      nextState = ADDIEX;
                    OP_J:         nextState = JUMP;
                    OP_JAL:       nextState = JALX;
                    default:      nextState = illegalTarget;
                endcase
            end
            MEMADR: nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = MEMWB;
            RTEX:   nextState = functLegal ? RTWB : illegalTarget;
            ADDIEX: nextState = ADDIWB;
            JALX:   nextState = JALW;
            HALT:   nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    // Outputs are registered by decoding the state about to be entered.
    always_comb begin
        ctrlNext = ctrlFor(nextState, functAlu);
    end

    // State, registered control word and the bne flag latched in DECODE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            curState <= FETCH;
            ctrlReg  <= ctrlFor(FETCH, ALU_ADD);
`ifdef BNE_SUPPORT_EN
            bneFlag  <= 1'b0;
`endif
        end else begin
            curState <= nextState;
            ctrlReg  <= ctrlNext;
`ifdef BNE_SUPPORT_EN
            if (curState == DECODE) begin
                bneFlag <= (opcode == OP_BNE);
            end
`endif
        end
    end

`ifdef BNE_SUPPORT_EN
    assign branchTaken = zero ^ bneFlag;
`else
    assign branchTaken = zero;
`endif

    // zero arrives combinationally from the ALU during BRANCH, so the branch
    // PC enable cannot be registered; write strobes are masked while in reset
    // so the FETCH word still drives all selects.
    assign PCWrite        = ~reset & (ctrlReg.pcWrite | (ctrlReg.branchEnable & branchTaken));
    assign IRWrite        = ~reset & ctrlReg.irWrite;
    assign memWrite       = ~reset & ctrlReg.memWrite;
    assign regWriteEnable = ~reset & ctrlReg.regWrite;
    assign IorD           = ctrlReg.iorD;
    assign memToReg       = ctrlReg.memToReg;
    assign regDst         = ctrlReg.regDst;
    assign jump           = ctrlReg.jump;
    assign ALUSrcA        = ctrlReg.aluSrcA;
    assign ALUSrcB        = ctrlReg.aluSrcB;
    assign ALUControl     = ctrlReg.aluControl;
    assign PCSrc          = ctrlReg.pcSrc;
    assign branchEnable   = ctrlReg.branchEnable;
    assign jumpReg        = ctrlReg.jumpReg;
    assign state          = curState;

endmodule

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control
// ----------------------------------------------------------------------------
// Scoreboard bench for multicycle_control. Each instruction is expanded into
// its per-cycle state walk from the instruction class; the expected control
// word for every cycle is queued, and a negedge monitor pops and compares.
// ============================================================================
module tb_multicycle_control;

    localparam bit HALT_ON_ILLEGAL = 1'b1;
`ifdef BNE_SUPPORT_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    localparam logic [4:0] A_ADD = 5'b00010;
    localparam logic [4:0] A_SUB = 5'b00110;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
    logic        PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, jump;
    logic        regWriteEnable, ALUSrcA, branchEnable, jumpReg;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [4:0]  ALUControl;
    logic [3:0]  state;

    typedef struct packed {
        logic [3:0] st;
        logic       pcWrite;
        logic       iorD;
        logic       irWrite;
        logic       memWrite;
        logic       memToReg;
        logic       regDst;
        logic       jump;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [4:0] aluControl;
        logic [1:0] pcSrc;
        logic       branchEnable;
        logic       jumpReg;
    } obsT;

    obsT        expectedQ[$];
    int         seqQ[$];
    bit         haltPending;
    bit         monActive   = 1'b0;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [5:0] legalFnTable [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    multicycle_control #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) dut (
        .clock(clock), .reset(reset), .instr(instr), .zero(zero),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .memWrite(memWrite),
        .memToReg(memToReg), .regDst(regDst), .jump(jump),
        .regWriteEnable(regWriteEnable), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .branchEnable(branchEnable),
        .jumpReg(jumpReg), .state(state)
    );

    // 10-unit clock period.
    initial forever #5 clock = ~clock;

    function automatic bit legalFunct(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    endfunction

    function automatic bit legalOpcode(input logic [5:0] op);
        return (op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h08, 6'h23, 6'h2B}) ||
               (BNE_EN && op == 6'h05);
    endfunction

    function automatic logic [4:0] functToAlu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 5'b00010;
            6'b100010: return 5'b00110;
            6'b100100: return 5'b00000;
            6'b100101: return 5'b00001;
            6'b101010: return 5'b00111;
            default:   return 5'b00010;
        endcase
    endfunction

    // Expected control word for one cycle spent in state st.
    function automatic obsT expectFor(input int st, input logic [5:0] fn,
                                      input bit zeroV, input bit bneV, input bit inReset);
        obsT e;
        e            = '0;
        e.st         = 4'(st);
        e.aluControl = A_ADD;
        case (st)
            0:  begin e.irWrite = !inReset; e.pcWrite = !inReset; e.aluSrcB = 2'b01; end
            1:  e.aluSrcB = 2'b11;
            2:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            3:  e.iorD = 1'b1;
            4:  begin e.memToReg = 1'b1; e.regWrite = 1'b1; end
            5:  begin e.iorD = 1'b1; e.memWrite = 1'b1; end
            6:  begin e.aluSrcA = 1'b1; e.aluControl = functToAlu(fn); end
            7:  begin e.regDst = 1'b1; e.regWrite = 1'b1; end
            8:  begin
                e.aluSrcA      = 1'b1;
                e.aluControl   = A_SUB;
                e.branchEnable = 1'b1;
                e.pcSrc        = 2'b01;
                e.pcWrite      = bneV ? !zeroV : zeroV;
            end
            9:  begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            10: e.regWrite = 1'b1;
            11: begin e.pcSrc = 2'b10; e.pcWrite = 1'b1; end
            12: e.aluControl = 5'b01000;
            13: begin e.jump = 1'b1; e.regWrite = 1'b1; e.pcSrc = 2'b10; e.pcWrite = 1'b1; end
            14: begin e.jumpReg = 1'b1; e.pcSrc = 2'b11; e.pcWrite = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obsT sampleDut();
        obsT g;
        g = '{state, PCWrite, IorD, IRWrite, memWrite, memToReg, regDst, jump,
              regWriteEnable, ALUSrcA, ALUSrcB, ALUControl, PCSrc, branchEnable, jumpReg};
        return g;
    endfunction

    // Monitor: one expected control word per clock cycle, compared mid-cycle.
    task automatic checkOutput();
        obsT got;
        obsT want;
        got = sampleDut();
        vectors++;
        if (expectedQ.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL underflow at %0t: got %h, nothing expected", $time, got);
        end else begin
            want = expectedQ.pop_front();
            if (got !== want) begin
                miscompares++;
                $display("[TB] FAIL ctrl@state%0d at %0t: got %h required %h",
                         want.st, $time, got, want);
            end
        end
    endtask

    always @(negedge clock) begin
        if (monActive) checkOutput();
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic applyReset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) expectedQ.push_back(expectFor(0, 6'h00, 1'b0, 1'b0, 1'b1));
        waitCycles(n);
        reset = 1'b0;
    endtask

    // State walk of one instruction derived from its class.
    task automatic buildSequence(input logic [31:0] iv);
        logic [5:0] op;
        logic [5:0] fn;
        bit         illegal;
        op          = iv[31:26];
        fn          = iv[5:0];
        illegal     = 1'b0;
        haltPending = 1'b0;
        seqQ        = '{0, 1};
        case (op)
            6'h23: begin seqQ.push_back(2); seqQ.push_back(3); seqQ.push_back(4); end
            6'h2B: begin seqQ.push_back(2); seqQ.push_back(5); end
            6'h00: begin
                if (fn == 6'b001000) seqQ.push_back(14);
                else begin
                    seqQ.push_back(6);
                    if (legalFunct(fn)) seqQ.push_back(7);
                    else illegal = 1'b1;
                end
            end
            6'h04: seqQ.push_back(8);
            6'h05: if (BNE_EN) seqQ.push_back(8); else illegal = 1'b1;
            6'h08: begin seqQ.push_back(9); seqQ.push_back(10); end
            6'h02: seqQ.push_back(11);
            6'h03: begin seqQ.push_back(12); seqQ.push_back(13); end
            default: illegal = 1'b1;
        endcase
        if (illegal && HALT_ON_ILLEGAL) begin
            for (int i = 0; i < 3; i++) seqQ.push_back(15);
            haltPending = 1'b1;
        end
    endtask

    // Drives one instruction; abortAfter >= 0 asserts reset after that many cycles.
    task automatic applyStimulus(input logic [31:0] iv, input bit zeroV, input int abortAfter);
        int n;
        bit bneV;
        buildSequence(iv);
        instr = iv;
        zero  = zeroV;
        bneV  = BNE_EN && (iv[31:26] == 6'h05);
        n     = (abortAfter >= 0) ? abortAfter : seqQ.size();
        for (int i = 0; i < n; i++)
            expectedQ.push_back(expectFor(seqQ[i], iv[5:0], zeroV, bneV, 1'b0));
        waitCycles(n);
        if (abortAfter >= 0 || haltPending) applyReset(1);
    endtask

    task automatic randomInstr(output logic [31:0] iv);
        logic [31:0] rnd;
        logic [5:0]  op;
        logic [5:0]  fn;
        int          k;
        rnd = $urandom();
        case ($urandom_range(0, 11))
            0, 11: iv = {6'h23, rnd[25:0]};
            1:     iv = {6'h2B, rnd[25:0]};
            2, 3:  begin
                k = $urandom_range(0, 5);
                if (k < 5) fn = legalFnTable[k];
                else begin
                    fn = 6'($urandom_range(0, 63));
                    if (legalFunct(fn) || fn == 6'b001000) fn = 6'h3F;
                end
                iv = {6'h00, rnd[25:6], fn};
            end
            4:     iv = {6'h00, rnd[25:6], 6'b001000};
            5:     iv = {6'h04, rnd[25:0]};
            6:     iv = {6'h05, rnd[25:0]};
            7:     iv = {6'h08, rnd[25:0]};
            8:     iv = {6'h02, rnd[25:0]};
            9:     iv = {6'h03, rnd[25:0]};
            default: begin
                op = 6'($urandom_range(0, 63));
                if (legalOpcode(op)) op = 6'h3F;
                iv = {op, rnd[25:0]};
            end
        endcase
    endtask

    initial begin
        logic [31:0] iv;
        reset = 1'b1;
        instr = 32'h0;
        zero  = 1'b0;
        @(posedge clock);
        #1;
        monActive = 1'b1;
        applyReset(2);

        applyStimulus(32'h8C220004, 1'b0, -1);   // lw
        applyStimulus(32'hAC220004, 1'b0, -1);   // sw
        applyStimulus(32'h10220003, 1'b1, -1);   // beq taken
        applyStimulus(32'h10220003, 1'b0, -1);   // beq not taken
        applyStimulus(32'h00221825, 1'b0, -1);   // or
        applyStimulus(32'h03E00008, 1'b0, -1);   // jr
        applyStimulus(32'h0C000010, 1'b0, -1);   // jal
        applyStimulus(32'h8C220004, 1'b0, 3);    // lw aborted in MEMRD
        applyStimulus(32'hFC000000, 1'b0, -1);   // illegal opcode
        applyStimulus(32'h14220003, 1'b0, -1);   // bne (or illegal)
        applyStimulus(32'h14220003, 1'b1, -1);

        for (int i = 0; i < 150; i++) begin
            randomInstr(iv);
            applyStimulus(iv, 1'($urandom_range(0, 1)), -1);
        end

        monActive = 1'b0;
        vectors++;
        if (expectedQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL leftover: %0d expected cycles not observed, required 0",
                     expectedQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
